seq_divider: RTL and testbench

//   Iterative radix-2 restoring unsigned divider, WIDTH-bit / WIDTH-bit.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// The master drives operands and out_ready. The slave (the divider) drives the result side.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per clock,
// with valid/ready handshakes on the operand side and the result side.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] q_next_s;

  // Next-state, restoring-step datapath and handshake control
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    // The partial remainder is always below the divisor, so it fits in WIDTH bits.
    // Only the trial difference needs the extra bit, which serves as the borrow flag.
    trial_s = {rem_q, q_q[WIDTH-1]} - {1'b0, d_q};
    if (trial_s[WIDTH] == 1'b0) begin
      rem_next_s = trial_s[WIDTH-1:0];
      q_next_s   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};
      q_next_s   = {q_q[WIDTH-2:0], 1'b0};
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid == 1'b1) begin
          in_ready_d = 1'b0;
          if (bus.divisor == {WIDTH{1'b0}}) begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = {WIDTH{1'b0}};
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            cnt_d   = CW'(WIDTH);
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = rem_next_s;
        q_d   = q_next_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quotient_d  = q_next_s;
          remainder_d = rem_next_s;
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready == 1'b1) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= {WIDTH{1'b0}};
      q_q         <= {WIDTH{1'b0}};
      d_q         <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a 32-bit and an 8-bit instance, directed plus randomized
// divisions checked against plain-arithmetic division.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) bus32 ();
  seq_divider_if #(.WIDTH(8))  bus8 ();

  seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  int checks = 0;
  int passes = 0;
  int w = 32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] f_q();
    return (w == 8) ? {24'd0, bus8.quotient} : bus32.quotient;
  endfunction
  function automatic logic [31:0] f_r();
    return (w == 8) ? {24'd0, bus8.remainder} : bus32.remainder;
  endfunction
  function automatic logic f_z();
    return (w == 8) ? bus8.div_by_zero : bus32.div_by_zero;
  endfunction
  function automatic logic f_ov();
    return (w == 8) ? bus8.out_valid : bus32.out_valid;
  endfunction
  function automatic logic f_rdy();
    return (w == 8) ? bus8.in_ready : bus32.in_ready;
  endfunction

  task automatic drive_in(input logic v, input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      bus8.in_valid = v;
      bus8.dividend = a[7:0];
      bus8.divisor  = b[7:0];
    end else begin
      bus32.in_valid = v;
      bus32.dividend = a;
      bus32.divisor  = b;
    end
  endtask

  task automatic set_out_ready(input logic v);
    bus32.out_ready = v;
    bus8.out_ready  = v;
  endtask

  // Reference: ordinary integer division; divide by zero gives all-ones and the dividend.
  task automatic model(input logic [31:0] a_in, input logic [31:0] b_in,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    logic [31:0] mask;
    logic [31:0] a;
    logic [31:0] b;
    mask = (w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    if (b == 32'd0) begin
      q = mask; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold, input bit pulse);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
    int          cyc;
    model(a, b, eq, er, ez);
    @(negedge clk);
    cyc = 0;
    while (!f_rdy() && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_ready_before_accept", {31'd0, f_rdy()}, 32'd1);
    drive_in(1'b1, a, b);
    @(posedge clk);
    #1 drive_in(1'b0, $urandom, $urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (pulse && cyc == 5) drive_in(1'b1, $urandom, 32'd1);
      else if (pulse && cyc == 6) drive_in(1'b0, $urandom, $urandom);
    end while (!f_ov() && cyc < 100);
    chk("latency", cyc, ez ? 32'd1 : 32'(w + 1));
    chk("quotient", f_q(), eq);
    chk("remainder", f_r(), er);
    chk("div_by_zero", {31'd0, f_z()}, {31'd0, ez});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, f_ov()}, 32'd1);
      chk("hold_in_ready", {31'd0, f_rdy()}, 32'd0);
      chk("hold_quotient", f_q(), eq);
      chk("hold_remainder", f_r(), er);
    end
    set_out_ready(1'b1);
    @(posedge clk);
    #1 set_out_ready(1'b0);
    @(negedge clk);
    chk("out_valid_cleared", {31'd0, f_ov()}, 32'd0);
    chk("in_ready_restored", {31'd0, f_rdy()}, 32'd1);
    chk("quotient_kept", f_q(), eq);
    if (pulse) begin
      repeat (3) @(negedge clk);
      chk("no_second_result", {31'd0, f_ov()}, 32'd0);
    end
  endtask

  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    rst_n = 1'b0;
    bus32.in_valid = 1'b0; bus32.dividend = 32'd0; bus32.divisor = 32'd0;
    bus8.in_valid  = 1'b0; bus8.dividend  = 8'd0;  bus8.divisor  = 8'd0;
    set_out_ready(1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus32.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus32.in_ready}, 32'd1);
    chk("rst_quotient", bus32.quotient, 32'd0);
    chk("rst_remainder", bus32.remainder, 32'd0);
    chk("rst_div_by_zero", {31'd0, bus32.div_by_zero}, 32'd0);
    chk("rst8_in_ready", {31'd0, bus8.in_ready}, 32'd1);

    w = 32;
    do_op(32'd100, 32'd7, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(32'd3, 32'd7, 0, 1'b0);
    do_op(32'd0, 32'd5, 0, 1'b0);
    do_op(32'd5, 32'd0, 0, 1'b0);
    do_op(32'd9, 32'd3, 0, 1'b0);
    do_op(32'd1000, 32'd3, 10, 1'b1);

    // Abort a division mid-flight: no result may appear and outputs return to zero.
    @(negedge clk);
    drive_in(1'b1, 32'd1000, 32'd3);
    @(posedge clk);
    #1 drive_in(1'b0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, bus32.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus32.in_ready}, 32'd1);
    chk("midrst_quotient", bus32.quotient, 32'd0);
    chk("midrst_remainder", bus32.remainder, 32'd0);
    chk("midrst_div_by_zero", {31'd0, bus32.div_by_zero}, 32'd0);
    repeat (40) @(negedge clk);
    chk("midrst_no_result", {31'd0, bus32.out_valid}, 32'd0);
    do_op(32'd1000, 32'd3, 0, 1'b0);

    w = 8;
    do_op(32'd200, 32'd7, 0, 1'b0);
    do_op(32'd255, 32'd0, 2, 1'b0);
    do_op(32'd255, 32'd255, 0, 1'b0);
    do_op(32'd3, 32'd7, 0, 1'b0);

    for (int pass = 0; pass < 2; pass++) begin
      w = (pass == 0) ? 32 : 8;
      for (int n = 0; n < ((pass == 0) ? 1100 : 1500); n++) begin
        case ($urandom_range(0, 7))
          0: rb = 32'd0;
          1: rb = 32'd1;
          2: rb = 32'hFFFF_FFFF;
          3: rb = $urandom_range(2, 15);
          default: rb = $urandom >> $urandom_range(0, 31);
        endcase
        case ($urandom_range(0, 5))
          0: ra = 32'd0;
          1: ra = 32'hFFFF_FFFF;
          default: ra = $urandom >> $urandom_range(0, 31);
        endcase
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_op(ra, rb, $urandom_range(0, 3), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
